vram_port_arbiter: RTL and testbench

//  Shares the single DDR/VRAM command port between three clients: display scanout (disp), render

---
 rtl/gpu_mem_pkg.sv | 30 +++
 rtl/vram_port_arbiter_if.sv | 81 ++++++++
 rtl/vram_owner_fifo.sv | 56 +++++
 rtl/vram_port_arbiter.sv | 113 +++++++++++
 tb/tb_vram_port_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_mem_pkg.sv
//------------------------------------------------------------------------------
// gpu_mem_pkg : shared GPU memory-port types (command sizes, client ids, bundle)
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package gpu_mem_pkg;

  localparam logic [1:0] CMD_8BYTE  = 2'd0;
  localparam logic [1:0] CMD_32BYTE = 2'd1;
  localparam logic [1:0] CMD_4BYTE  = 2'd2;

  typedef enum logic [1:0] {
    CLI_DISP = 2'd0,
    CLI_RNDR = 2'd1,
    CLI_CPU  = 2'd2
  } clientId_t;

  typedef struct packed {
    logic [1:0]   size;
    logic         write;
    logic [14:0]  adr;
    logic [2:0]   subadr;
    logic [15:0]  mask;
    logic [255:0] data;
  } cmdBundle_t;

endpackage

`default_nettype wire

// File: rtl/vram_port_arbiter_if.sv
//------------------------------------------------------------------------------
// vram_port_arbiter_if : client + DDR command/return signals of the VRAM port
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface vram_port_arbiter_if #(
  parameter int OUTSTANDING = 4
);
  logic         i_disp_command;
  logic [1:0]   i_disp_commandSize;
  logic [14:0]  i_disp_adr;
  logic [2:0]   i_disp_subadr;
  logic         o_disp_busy;
  logic         o_disp_dataInValid;

  logic         i_rndr_command;
  logic [1:0]   i_rndr_commandSize;
  logic         i_rndr_write;
  logic [14:0]  i_rndr_adr;
  logic [2:0]   i_rndr_subadr;
  logic [15:0]  i_rndr_writeMask;
  logic [255:0] i_rndr_dataOut;
  logic         o_rndr_busy;
  logic         o_rndr_dataInValid;

  logic         i_cpu_command;
  logic [1:0]   i_cpu_commandSize;
  logic         i_cpu_write;
  logic [14:0]  i_cpu_adr;
  logic [2:0]   i_cpu_subadr;
  logic [15:0]  i_cpu_writeMask;
  logic [255:0] i_cpu_dataOut;
  logic         o_cpu_busy;
  logic         o_cpu_dataInValid;

  logic         o_command;
  logic [1:0]   o_commandSize;
  logic         o_write;
  logic [14:0]  o_adr;
  logic [2:0]   o_subadr;
  logic [15:0]  o_writeMask;
  logic [255:0] o_dataOut;
  logic         i_busy;
  logic [255:0] i_dataIn;
  logic         i_dataInValid;
  logic         o_protoErr;
  logic [$clog2(OUTSTANDING):0] o_outstanding;

  // Read data is broadcast straight over the bus, so the arbiter never touches i_dataIn.
  modport slave (
    input  i_disp_command, i_disp_commandSize, i_disp_adr, i_disp_subadr,
    output o_disp_busy, o_disp_dataInValid,
    input  i_rndr_command, i_rndr_commandSize, i_rndr_write, i_rndr_adr, i_rndr_subadr,
    input  i_rndr_writeMask, i_rndr_dataOut,
    output o_rndr_busy, o_rndr_dataInValid,
    input  i_cpu_command, i_cpu_commandSize, i_cpu_write, i_cpu_adr, i_cpu_subadr,
    input  i_cpu_writeMask, i_cpu_dataOut,
    output o_cpu_busy, o_cpu_dataInValid,
    output o_command, o_commandSize, o_write, o_adr, o_subadr, o_writeMask, o_dataOut,
    input  i_busy, i_dataInValid,
    output o_protoErr, o_outstanding
  );

  modport master (
    output i_disp_command, i_disp_commandSize, i_disp_adr, i_disp_subadr,
    input  o_disp_busy, o_disp_dataInValid,
    output i_rndr_command, i_rndr_commandSize, i_rndr_write, i_rndr_adr, i_rndr_subadr,
    output i_rndr_writeMask, i_rndr_dataOut,
    input  o_rndr_busy, o_rndr_dataInValid,
    output i_cpu_command, i_cpu_commandSize, i_cpu_write, i_cpu_adr, i_cpu_subadr,
    output i_cpu_writeMask, i_cpu_dataOut,
    input  o_cpu_busy, o_cpu_dataInValid,
    input  o_command, o_commandSize, o_write, o_adr, o_subadr, o_writeMask, o_dataOut,
    output i_busy, i_dataIn, i_dataInValid,
    input  o_protoErr, o_outstanding
  );

endinterface

`default_nettype wire

// File: rtl/vram_owner_fifo.sv
//------------------------------------------------------------------------------
// vram_owner_fifo : in-order FIFO of read-owner ids for outstanding DDR reads
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vram_owner_fifo
  import gpu_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    gpuClk,
  input  logic                    i_nRst,
  input  logic                    i_push,
  input  clientId_t               i_pushId,
  input  logic                    i_pop,
  output clientId_t               o_headId,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);
  localparam int c_ptrW = $clog2(DEPTH);

  clientId_t         r_mem [DEPTH];
  logic [c_ptrW-1:0] r_wrPtr;
  logic [c_ptrW-1:0] r_rdPtr;
  logic [c_ptrW:0]   r_count;

  always_ff @(posedge gpuClk) begin
    if (i_push) r_mem[r_wrPtr] <= i_pushId;
  end

  always_ff @(posedge gpuClk) begin
    if (!i_nRst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + c_ptrW'(1);
      if (i_pop)  r_rdPtr <= r_rdPtr + c_ptrW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (c_ptrW+1)'(1);
        2'b01:   r_count <= r_count - (c_ptrW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_headId = r_mem[r_rdPtr];
  assign o_full   = (r_count == (c_ptrW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;

endmodule

`default_nettype wire

// File: rtl/vram_port_arbiter.sv
//------------------------------------------------------------------------------
// vram_port_arbiter : shares the DDR command port between disp/rndr/cpu clients
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vram_port_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic               gpuClk,
  input  logic               i_nRst,
  vram_port_arbiter_if.slave bus
);
  localparam int                 c_cntW    = $clog2(OUTSTANDING) + 1;
  localparam int                 c_waitW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_waitW-1:0] c_waitMax = c_waitW'(STARVE_LIMIT);

  logic              w_full;
  logic              w_empty;
  logic [c_cntW-1:0] w_count;
  clientId_t         w_headId;
  clientId_t         w_pushId;
  cmdBundle_t        w_sel;
  logic              w_eligDisp, w_eligRndr, w_eligCpu;
  logic              w_starved, w_active;
  logic              w_grantDisp, w_grantRndr, w_grantCpu;
  logic              w_push, w_pop;
  logic [c_waitW-1:0] r_cpuWait;
  logic              r_protoErr;

  // Writes never occupy an owner slot, so only reads are blocked by a full FIFO.
  assign w_eligDisp = bus.i_disp_command & ~w_full;
  assign w_eligRndr = bus.i_rndr_command & (bus.i_rndr_write | ~w_full);
  assign w_eligCpu  = bus.i_cpu_command  & (bus.i_cpu_write  | ~w_full);

  assign w_starved   = (r_cpuWait == c_waitMax);
  assign w_active    = i_nRst & ~bus.i_busy;
  assign w_grantDisp = w_active & w_eligDisp;
  assign w_grantCpu  = w_active & ~w_eligDisp & w_eligCpu & (w_starved | ~w_eligRndr);
  assign w_grantRndr = w_active & ~w_eligDisp & w_eligRndr & ~(w_starved & w_eligCpu);

  always_comb begin
    w_sel    = '0;
    w_pushId = CLI_DISP;
    if (w_grantDisp) begin
      w_sel.size   = bus.i_disp_commandSize;
      w_sel.adr    = bus.i_disp_adr;
      w_sel.subadr = bus.i_disp_subadr;
    end else if (w_grantRndr) begin
      w_sel    = '{bus.i_rndr_commandSize, bus.i_rndr_write, bus.i_rndr_adr,
                   bus.i_rndr_subadr, bus.i_rndr_writeMask, bus.i_rndr_dataOut};
      w_pushId = CLI_RNDR;
    end else if (w_grantCpu) begin
      w_sel    = '{bus.i_cpu_commandSize, bus.i_cpu_write, bus.i_cpu_adr,
                   bus.i_cpu_subadr, bus.i_cpu_writeMask, bus.i_cpu_dataOut};
      w_pushId = CLI_CPU;
    end
  end

  assign bus.o_command     = w_grantDisp | w_grantRndr | w_grantCpu;
  assign bus.o_commandSize = w_sel.size;
  assign bus.o_write       = w_sel.write;
  assign bus.o_adr         = w_sel.adr;
  assign bus.o_subadr      = w_sel.subadr;
  assign bus.o_writeMask   = w_sel.mask;
  assign bus.o_dataOut     = w_sel.data;

  assign bus.o_disp_busy = ~w_grantDisp;
  assign bus.o_rndr_busy = ~w_grantRndr;
  assign bus.o_cpu_busy  = ~w_grantCpu;

  assign w_push = bus.o_command & ~w_sel.write;
  assign w_pop  = i_nRst & bus.i_dataInValid & ~w_empty;

  assign bus.o_disp_dataInValid = w_pop & (w_headId == CLI_DISP);
  assign bus.o_rndr_dataInValid = w_pop & (w_headId == CLI_RNDR);
  assign bus.o_cpu_dataInValid  = w_pop & (w_headId == CLI_CPU);

  vram_owner_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_ownerFifo (
    .gpuClk   (gpuClk),
    .i_nRst   (i_nRst),
    .i_push   (w_push),
    .i_pushId (w_pushId),
    .i_pop    (w_pop),
    .o_headId (w_headId),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_count  (w_count)
  );

  // cpu ages only while it actually asks and loses; any gap in its request restarts the count.
  always_ff @(posedge gpuClk) begin
    if (!i_nRst) begin
      r_cpuWait  <= '0;
      r_protoErr <= 1'b0;
    end else begin
      if (!bus.i_cpu_command || w_grantCpu) r_cpuWait <= '0;
      else if (!w_starved)                  r_cpuWait <= r_cpuWait + c_waitW'(1);
      if (bus.i_dataInValid && w_empty)     r_protoErr <= 1'b1;
    end
  end

  assign bus.o_protoErr    = r_protoErr;
  assign bus.o_outstanding = w_count;

endmodule

`default_nettype wire

// File: tb/tb_vram_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_vram_port_arbiter : directed + random stimulus against a queue-based model
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_vram_port_arbiter;
  import gpu_mem_pkg::*;

  localparam int OUTSTANDING  = 4;
  localparam int STARVE_LIMIT = 16;

  logic gpuClk = 1'b0;
  logic nRst;
  always #5 gpuClk = ~gpuClk;

  vram_port_arbiter_if #(.OUTSTANDING(OUTSTANDING)) bus();

  vram_port_arbiter #(
    .OUTSTANDING  (OUTSTANDING),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .gpuClk (gpuClk),
    .i_nRst (nRst),
    .bus    (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  int ownerQ[$];
  bit mProtoErr;
  int mCpuWait;
  int lastWinner;
  bit dutCpuGrant;
  logic [1:0] sizeTab [3];

  task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearAll();
    bus.i_disp_command = 1'b0;
    bus.i_rndr_command = 1'b0;
    bus.i_cpu_command  = 1'b0;
    bus.i_busy         = 1'b0;
    bus.i_dataInValid  = 1'b0;
  endtask

  // Load client c with a fresh random request (wr is forced to 0 for disp).
  task automatic setCmd(input int c, input bit wr, input logic [14:0] adr);
    logic [1:0] sz;
    logic [2:0] sub;
    logic [15:0] msk;
    logic [255:0] dat;
    sz  = sizeTab[$urandom_range(0, 2)];
    sub = 3'($urandom_range(0, 7));
    msk = 16'($urandom());
    dat = {8{$urandom()}};
    case (c)
      0: begin
        bus.i_disp_command = 1'b1; bus.i_disp_commandSize = sz;
        bus.i_disp_adr = adr; bus.i_disp_subadr = sub;
      end
      1: begin
        bus.i_rndr_command = 1'b1; bus.i_rndr_commandSize = sz; bus.i_rndr_write = wr;
        bus.i_rndr_adr = adr; bus.i_rndr_subadr = sub; bus.i_rndr_writeMask = msk;
        bus.i_rndr_dataOut = dat;
      end
      default: begin
        bus.i_cpu_command = 1'b1; bus.i_cpu_commandSize = sz; bus.i_cpu_write = wr;
        bus.i_cpu_adr = adr; bus.i_cpu_subadr = sub; bus.i_cpu_writeMask = msk;
        bus.i_cpu_dataOut = dat;
      end
    endcase
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model, step past the edge.
  task automatic step();
    bit cmd [3];
    bit wr [3];
    bit expValid [3];
    int order [3];
    int win;
    int owner;
    logic [1:0]   eSize;
    logic         eWr;
    logic [14:0]  eAdr;
    logic [2:0]   eSub;
    logic [15:0]  eMsk;
    logic [255:0] eDat;
    @(negedge gpuClk);
    cmd[0] = bus.i_disp_command; cmd[1] = bus.i_rndr_command; cmd[2] = bus.i_cpu_command;
    wr[0]  = 1'b0;               wr[1]  = bus.i_rndr_write;   wr[2]  = bus.i_cpu_write;
    expValid[0] = 0; expValid[1] = 0; expValid[2] = 0;
    win = -1;
    checkVal("outstanding", bus.o_outstanding, ownerQ.size());
    checkVal("protoErr", bus.o_protoErr, mProtoErr);
    if (!nRst) begin
      ownerQ.delete();
      mProtoErr = 0;
      mCpuWait  = 0;
    end else begin
      order[0] = 0;
      if (mCpuWait == STARVE_LIMIT) begin order[1] = 2; order[2] = 1; end
      else                          begin order[1] = 1; order[2] = 2; end
      if (!bus.i_busy)
        for (int k = 0; k < 3; k++)
          if (win < 0 && cmd[order[k]] && (wr[order[k]] || ownerQ.size() < OUTSTANDING))
            win = order[k];
      if (bus.i_dataInValid) begin
        if (ownerQ.size() > 0) begin owner = ownerQ.pop_front(); expValid[owner] = 1; end
        else mProtoErr = 1;
      end
      if (win >= 0 && !wr[win]) ownerQ.push_back(win);
      if (cmd[2] && win != 2) mCpuWait = (mCpuWait < STARVE_LIMIT) ? mCpuWait + 1 : mCpuWait;
      else                    mCpuWait = 0;
    end
    checkVal("command",   bus.o_command,   win >= 0);
    checkVal("dispBusy",  bus.o_disp_busy, win != 0);
    checkVal("rndrBusy",  bus.o_rndr_busy, win != 1);
    checkVal("cpuBusy",   bus.o_cpu_busy,  win != 2);
    checkVal("dispValid", bus.o_disp_dataInValid, expValid[0]);
    checkVal("rndrValid", bus.o_rndr_dataInValid, expValid[1]);
    checkVal("cpuValid",  bus.o_cpu_dataInValid,  expValid[2]);
    if (win >= 0) begin
      case (win)
        0: begin eSize = bus.i_disp_commandSize; eWr = 1'b0; eAdr = bus.i_disp_adr;
                 eSub = bus.i_disp_subadr; eMsk = '0; eDat = '0; end
        1: begin eSize = bus.i_rndr_commandSize; eWr = bus.i_rndr_write; eAdr = bus.i_rndr_adr;
                 eSub = bus.i_rndr_subadr; eMsk = bus.i_rndr_writeMask; eDat = bus.i_rndr_dataOut; end
        default: begin eSize = bus.i_cpu_commandSize; eWr = bus.i_cpu_write; eAdr = bus.i_cpu_adr;
                 eSub = bus.i_cpu_subadr; eMsk = bus.i_cpu_writeMask; eDat = bus.i_cpu_dataOut; end
      endcase
      checkVal("cmdSize", bus.o_commandSize, eSize);
      checkVal("cmdWrite", bus.o_write, eWr);
      checkVal("cmdAdr", bus.o_adr, eAdr);
      checkVal("cmdSubadr", bus.o_subadr, eSub);
      if (eWr) begin
        checkVal("cmdMask", bus.o_writeMask, eMsk);
        checkVal("cmdData", bus.o_dataOut, eDat);
      end
    end
    lastWinner  = win;
    dutCpuGrant = !bus.o_cpu_busy;
    @(posedge gpuClk);
    #1;
  endtask

  // Drop any request the model says was accepted this cycle.
  task automatic retire();
    if (lastWinner == 0) bus.i_disp_command = 1'b0;
    if (lastWinner == 1) bus.i_rndr_command = 1'b0;
    if (lastWinner == 2) bus.i_cpu_command  = 1'b0;
  endtask

  task automatic doReset();
    clearAll();
    nRst = 1'b0;
    step();
    nRst = 1'b1;
  endtask

  initial begin
    int waitCycles;
    sizeTab[0] = CMD_8BYTE; sizeTab[1] = CMD_32BYTE; sizeTab[2] = CMD_4BYTE;
    mProtoErr = 0; mCpuWait = 0; lastWinner = -1; dutCpuGrant = 0;
    nRst = 1'b0;
    bus.i_dataIn = '0;
    clearAll();
    setCmd(1, 1'b0, 15'h0); bus.i_rndr_command = 1'b0;
    setCmd(2, 1'b0, 15'h0); bus.i_cpu_command  = 1'b0;
    setCmd(0, 1'b0, 15'h0); bus.i_disp_command = 1'b0;
    repeat (2) @(posedge gpuClk);
    #1;
    doReset();

    // Single rndr read, then its return beat.
    setCmd(1, 1'b0, 15'h1234);
    step(); retire();
    bus.i_dataInValid = 1'b1;
    step();
    bus.i_dataInValid = 1'b0;

    // Three simultaneous reads served disp, rndr, cpu; returns routed in the same order.
    setCmd(0, 1'b0, 15'h0100); setCmd(1, 1'b0, 15'h0200); setCmd(2, 1'b0, 15'h0300);
    repeat (3) begin step(); retire(); end
    bus.i_dataInValid = 1'b1;
    repeat (3) step();
    bus.i_dataInValid = 1'b0;

    // Starvation: rndr writes every cycle, cpu write waits for the promotion.
    step();
    setCmd(1, 1'b1, 15'h0400); setCmd(2, 1'b1, 15'h0500);
    waitCycles = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      waitCycles++;
      if (dutCpuGrant) break;
      setCmd(1, 1'b1, 15'(n));
    end
    checkVal("starveGrantCycle", waitCycles, 17);
    bus.i_cpu_command = 1'b0;
    step(); step();

    // Fill the owner FIFO, then hold a 5th read while a cpu write slips through.
    bus.i_rndr_command = 1'b0;
    repeat (4) begin setCmd(0, 1'b0, 15'h0600); step(); retire(); end
    setCmd(0, 1'b0, 15'h0700); setCmd(2, 1'b1, 15'h0701);
    step(); retire();
    checkVal("fullOutstanding", bus.o_outstanding, 4);
    bus.i_dataInValid = 1'b1;
    step(); retire();
    step(); retire();
    bus.i_dataInValid = 1'b0;
    repeat (3) begin step(); retire(); end

    // Return with nothing outstanding, then reset with reads in flight.
    doReset();
    bus.i_dataInValid = 1'b1;
    step();
    bus.i_dataInValid = 1'b0;
    repeat (3) step();
    repeat (3) begin setCmd(2, 1'b0, 15'h0800); step(); retire(); end
    doReset();
    bus.i_dataInValid = 1'b1;
    step();
    bus.i_dataInValid = 1'b0;
    step();
    doReset();

    // Random traffic with held requests, DDR backpressure and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (!bus.i_disp_command && $urandom_range(0, 3) == 0) setCmd(0, 1'b0, 15'($urandom()));
      if (!bus.i_rndr_command && $urandom_range(0, 1) == 0)
        setCmd(1, $urandom_range(0, 1) == 0, 15'($urandom()));
      if (!bus.i_cpu_command && $urandom_range(0, 2) == 0)
        setCmd(2, $urandom_range(0, 2) == 0, 15'($urandom()));
      bus.i_busy        = ($urandom_range(0, 4) == 0);
      bus.i_dataIn      = {8{$urandom()}};
      bus.i_dataInValid = (ownerQ.size() > 0) ? ($urandom_range(0, 2) == 0)
                                              : ($urandom_range(0, 60) == 0);
      nRst = ($urandom_range(0, 200) != 0);
      step();
      retire();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
